// File: rtl/neptuno_joy_scanner.sv
// Neptuno serial joystick port sequencer: loads and clocks the board shift register,
// walks the Sega select line through eight phases and publishes latched frames.
module neptuno_joy_scanner #(
  parameter int CLK_DIV       = 16,
  parameter int NBITS         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int IDLE_CYCLES   = 100000,
  parameter logic [NBITS-1:0] DET_MASK_A = NBITS'('h000F),
  parameter logic [NBITS-1:0] DET_MASK_B = NBITS'('h0F00)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             JOY_CLK,
  output logic             JOY_LOAD,
  input  logic             JOY_DATA,
  output logic             joyP7_o,
  output logic [NBITS-1:0] frame_hi,
  output logic [NBITS-1:0] frame_lo,
  output logic [NBITS-1:0] frame_ext,
  output logic             six_a,
  output logic             six_b,
  output logic             frame_strobe
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IDLE_W   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int BIT_W    = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(NBITS - 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_CAPTURE,
    ST_IDLE
  } state_t;

  state_t            state;
  logic [2:0]        phase;
  logic [DIV_W-1:0]  div_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [NBITS-1:0]  sr;
  logic [1:0]        data_sync;
  logic              data_s;
  logic              div_last;

  // JOY_DATA comes from the board asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sync <= 2'b00;
    end else begin
      data_sync <= {data_sync[0], JOY_DATA};
    end
  end

  assign data_s   = data_sync[1];
  assign div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_SETTLE;
      phase        <= 3'd0;
      div_cnt      <= '0;
      settle_cnt   <= '0;
      idle_cnt     <= '0;
      bit_cnt      <= '0;
      sr           <= '1;
      JOY_CLK      <= 1'b0;
      JOY_LOAD     <= 1'b1;
      joyP7_o      <= 1'b1;
      frame_hi     <= '1;
      frame_lo     <= '1;
      frame_ext    <= '1;
      six_a        <= 1'b0;
      six_b        <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            JOY_LOAD   <= 1'b0;
            state      <= ST_LOAD;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (div_last) begin
            div_cnt  <= '0;
            JOY_LOAD <= 1'b1;
            bit_cnt  <= '0;
            state    <= ST_SHIFT_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // Sampling at the end of the low half leaves time for the synchronizer.
        ST_SHIFT_LO: begin
          if (div_last) begin
            div_cnt <= '0;
            sr      <= {sr[NBITS-2:0], data_s};
            if (bit_cnt == BIT_LAST) begin
              state <= ST_CAPTURE;
            end else begin
              JOY_CLK <= 1'b1;
              state   <= ST_SHIFT_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_SHIFT_HI: begin
          if (div_last) begin
            div_cnt <= '0;
            JOY_CLK <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            state   <= ST_SHIFT_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_CAPTURE: begin
          case (phase)
            3'd0: frame_hi <= sr;
            3'd1: frame_lo <= sr;
            3'd5: begin
              six_a <= ((sr & DET_MASK_A) == '0);
              six_b <= ((sr & DET_MASK_B) == '0);
            end
            3'd6: frame_ext <= sr;
            default: ;
          endcase
          if (phase == 3'd7) begin
            phase        <= 3'd0;
            frame_strobe <= 1'b1;
            joyP7_o      <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            phase   <= phase + 3'd1;
            // next phase's select is ~(phase+1)[0], which equals phase[0]
            joyP7_o <= phase[0];
            state   <= ST_SETTLE;
          end
        end

        ST_IDLE: begin
          if (idle_cnt == IDLE_LAST) begin
            idle_cnt <= '0;
            joyP7_o  <= 1'b1;
            state    <= ST_SETTLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neptuno_joy_scanner.sv
// Directed bench for neptuno_joy_scanner: a behavioural shift-register pad model
// feeds per-phase patterns; frames, flags and port timing are checked against hand values.
module tb_neptuno_joy_scanner;

  localparam int CLK_DIV       = 4;
  localparam int NBITS         = 16;
  localparam int SETTLE_CYCLES = 8;
  localparam int IDLE_CYCLES   = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        joy_data = 1'b1;
  logic        jclk, jload, sel;
  logic [15:0] fhi, flo, fext;
  logic        six_a, six_b, strobe;

  neptuno_joy_scanner #(
    .CLK_DIV(CLK_DIV), .NBITS(NBITS), .SETTLE_CYCLES(SETTLE_CYCLES),
    .IDLE_CYCLES(IDLE_CYCLES), .DET_MASK_A(16'h000F), .DET_MASK_B(16'h0F00)
  ) dut (
    .clk(clk), .reset(reset), .JOY_CLK(jclk), .JOY_LOAD(jload), .JOY_DATA(joy_data),
    .joyP7_o(sel), .frame_hi(fhi), .frame_lo(flo), .frame_ext(fext),
    .six_a(six_a), .six_b(six_b), .frame_strobe(strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Pad model: parallel load picks the pattern for the load index, MSB out first.
  logic [15:0] pat [8];
  logic [15:0] msr;
  logic        model_bit;
  int          load_idx;
  logic        sel_log [8];
  bit          jitter_en = 0;
  event        model_ev;

  always @(negedge jload or posedge jclk or posedge reset) begin
    if (reset) begin
      load_idx = 0;
    end else if (!jload) begin
      sel_log[load_idx % 8] = sel;
      msr = pat[load_idx % 8];
      load_idx++;
      model_bit = msr[15];
      ->model_ev;
    end else begin
      msr = {msr[14:0], 1'b1};
      model_bit = msr[15];
      ->model_ev;
    end
  end

  // Optional garbage then a late, clock-unaligned settle of the data line
  initial begin
    forever begin
      @(model_ev);
      if (jitter_en) begin
        joy_data = 1'($urandom);
        #($urandom_range(3, 25));
      end
      joy_data = model_bit;
    end
  end

  // Port timing monitor, sampled on the falling clock edge
  int   ncyc = 0, load_run = 0, last_load_len = 0, hi_run = 0, pulses = 0, last_pulses = 0;
  int   bad_len = 0, clk_in_load = 0, t_fall = 0, frame_len = 0, strobes = 0;
  int   gap_cnt = 0, gap_sel_bad = 0, last_gap = 0;
  bit   in_gap = 0;
  logic prev_load = 1'b1, prev_sel = 1'b1, prev_jclk = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (reset) begin
      load_run = 0; hi_run = 0; pulses = 0; strobes = 0; in_gap = 0; t_fall = 0;
      prev_load = 1'b1; prev_sel = 1'b1; prev_jclk = 1'b0;
    end else begin
      if (!jload) begin
        if (prev_load) begin
          last_pulses = pulses;
          pulses = 0;
        end
        load_run++;
      end else if (!prev_load) begin
        last_load_len = load_run;
        load_run = 0;
      end
      if (jclk) begin
        if (!prev_jclk) pulses++;
        hi_run++;
      end else if (prev_jclk) begin
        if (hi_run != CLK_DIV) bad_len++;
        hi_run = 0;
      end
      if (jclk && !jload) clk_in_load++;
      if (prev_sel && !sel) t_fall = ncyc;
      if (!prev_sel && sel && t_fall > 0) frame_len = ncyc - t_fall;
      if (strobe) begin
        strobes++;
        in_gap = 1;
        gap_cnt = 0;
      end else if (in_gap) begin
        gap_cnt++;
        if (!sel) gap_sel_bad++;
        if (!jload) begin
          in_gap = 0;
          last_gap = gap_cnt;
        end
      end
      prev_load = jload; prev_sel = sel; prev_jclk = jclk;
    end
  end

  task automatic wait_strobe(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (strobe) begin
        ok = 1;
        break;
      end
    end
    #1;
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic set_pats(input logic [15:0] p0, p1, p2, p3, p4, p5, p6, p7);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
    pat[4] = p4; pat[5] = p5; pat[6] = p6; pat[7] = p7;
  endtask

  initial begin
    bit          ok;
    logic [7:0]  sel_bits;

    set_pats(16'hA5C3, 16'h5A3C, 16'hA5C3, 16'h5A3C, 16'hA5C3, 16'hFFF0, 16'hFFF6, 16'h5A3C);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_jclk",   32'(jclk),   32'd0);
    check("rst_jload",  32'(jload),  32'd1);
    check("rst_sel",    32'(sel),    32'd1);
    check("rst_fhi",    32'(fhi),    32'hFFFF);
    check("rst_flo",    32'(flo),    32'hFFFF);
    check("rst_fext",   32'(fext),   32'hFFFF);
    check("rst_six_a",  32'(six_a),  32'd0);
    check("rst_six_b",  32'(six_b),  32'd0);
    check("rst_strobe", 32'(strobe), 32'd0);
    reset = 1'b0;

    // Cycle 1: clean data, timing and select sequence
    wait_strobe("strobe_c1");
    set_pats(16'h1234, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF0FF, 16'h0F0F, 16'hFFFF);
    check("c1_fhi",   32'(fhi),   32'hA5C3);
    check("c1_flo",   32'(flo),   32'h5A3C);
    check("c1_fext",  32'(fext),  32'hFFF6);
    check("c1_six_a", 32'(six_a), 32'd1);
    check("c1_six_b", 32'(six_b), 32'd0);
    for (int i = 0; i < 8; i++) sel_bits[i] = sel_log[i];
    check("c1_sel_seq",    32'(sel_bits),  32'h55);
    check("c1_load_len",   last_load_len,  32'd4);
    check("c1_pulses",     last_pulses,    32'd15);
    check("c1_pulse_len",  bad_len,        32'd0);
    check("c1_clk_in_load", clk_in_load,   32'd0);
    check("c1_frame_len",  frame_len,      32'd137);
    check("c1_strobes",    strobes,        32'd1);
    check("c1_loads",      load_idx,       32'd8);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (!in_gap) begin
        ok = 1;
        break;
      end
    end
    check("gap_end_seen", 32'(ok), 32'd1);
    check("gap_len",      last_gap,    32'd28);
    check("gap_sel_low",  gap_sel_bad, 32'd0);

    // Cycle 2: asynchronous, glitchy data line
    jitter_en = 1;
    wait_strobe("strobe_c2");
    check("c2_fhi",   32'(fhi),   32'h1234);
    check("c2_flo",   32'(flo),   32'h0000);
    check("c2_fext",  32'(fext),  32'h0F0F);
    check("c2_six_a", 32'(six_a), 32'd0);
    check("c2_six_b", 32'(six_b), 32'd1);
    check("c2_strobes", strobes,  32'd2);
    check("c2_no_x", 32'($isunknown({jclk, jload, sel, fhi, flo, fext, six_a, six_b, strobe})), 32'd0);

    // Reset in the middle of bit 7 of the phase-0 frame
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!jload) begin
        ok = 1;
        break;
      end
    end
    check("c3_load_seen", 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (pulses >= 7) begin
        ok = 1;
        break;
      end
    end
    check("c3_bit7_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_jclk",  32'(jclk),  32'd0);
    check("mid_jload", 32'(jload), 32'd1);
    check("mid_sel",   32'(sel),   32'd1);
    check("mid_fhi",   32'(fhi),   32'hFFFF);
    check("mid_flo",   32'(flo),   32'hFFFF);
    check("mid_fext",  32'(fext),  32'hFFFF);
    check("mid_six_b", 32'(six_b), 32'd0);
    check("mid_strobe", 32'(strobe), 32'd0);
    repeat (3) @(negedge clk);
    set_pats(16'h8001, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h7FFF, 16'hFFFF);
    reset = 1'b0;

    wait_strobe("strobe_c3");
    check("c3_fhi",   32'(fhi),   32'h8001);
    check("c3_flo",   32'(flo),   32'hFFFE);
    check("c3_fext",  32'(fext),  32'h7FFF);
    check("c3_six_a", 32'(six_a), 32'd1);
    check("c3_six_b", 32'(six_b), 32'd1);
    check("c3_loads", load_idx,   32'd8);
    check("c3_strobes", strobes,  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neptuno_joy_scanner.md
Name: neptuno_joy_scanner

Overview:
- Sequences the Neptuno serial joystick port: drives parallel-load and clock into the board's joystick shift register and reads JOY_DATA back.
- Drives the Sega select line (joyP7_o) through an 8-phase cycle to read 3- and 6-button pads.
- Publishes latched per-select frames and 6-button detection flags.
- Sits in the Neptuno top level beside the substitute MCU and feeds the guest joystick inputs.

Parameters:
- CLK_DIV, 16: system clocks per JOY_CLK half-period (≥1).
- NBITS, 16: bits shifted per frame.
- SETTLE_CYCLES, 64: clocks between a select change and the load pulse.
- IDLE_CYCLES, 100000: gap after phase 7 before a new cycle, for the pad's counter reset.
- DET_MASK_A, 16'h000F: pad A bits that must all be 0 in phase 5 to flag 6-button.
- DET_MASK_B, 16'h0F00: the same for pad B.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- JOY_CLK, out, 1: shift clock; the register shifts on the rising edge.
- JOY_LOAD, out, 1: active-low parallel load.
- JOY_DATA, in, 1: serial data, MSB first.
- joyP7_o, out, 1: Sega select.
- frame_hi, out, NBITS: frame captured in phase 0 (select=1).
- frame_lo, out, NBITS: frame captured in phase 1 (select=0).
- frame_ext, out, NBITS: frame captured in phase 6 (6-button extension).
- six_a, out, 1: pad A 6-button detected.
- six_b, out, 1: pad B 6-button detected.
- frame_strobe, out, 1: one-clock pulse when a full 8-phase cycle has been published.

Behaviour:
- Reset values, held while reset is high:
  - JOY_CLK=0, JOY_LOAD=1, joyP7_o=1.
  - frame_hi, frame_lo and frame_ext all ones (buttons are active-low).
  - six_a=0, six_b=0, frame_strobe=0.
  - phase=0, state=SETTLE, all counters 0.
- Reset asserted mid-operation aborts immediately to these values. After release, no partial frame is ever published.
- Select: joyP7_o = ~phase[0]. Phases 0/2/4/6 drive 1; phases 1/3/5/7 drive 0. joyP7_o changes only on entry to SETTLE.
- States and transitions:
  - SETTLE: JOY_CLK=0, JOY_LOAD=1. Lasts SETTLE_CYCLES clocks, then LOAD.
  - LOAD: JOY_LOAD=0, JOY_CLK=0 for CLK_DIV clocks. Then JOY_LOAD=1, bit counter=0, go to SHIFT_LO.
  - SHIFT_LO: JOY_CLK=0 for CLK_DIV clocks. On the last clock, sample JOY_DATA into shift reg bit (NBITS-1-bitcnt). If bitcnt=NBITS-1, go to CAPTURE; otherwise go to SHIFT_HI.
  - SHIFT_HI: JOY_CLK=1 for CLK_DIV clocks, then bitcnt+1, go to SHIFT_LO.
  - CAPTURE: one clock, actions by phase:
    - phase 0: shift reg → frame_hi.
    - phase 1: shift reg → frame_lo.
    - phase 5: update flags: six_a = ((sr & DET_MASK_A)==0), six_b likewise with DET_MASK_B.
    - phase 6: shift reg → frame_ext.
    - Phases 2, 3, 4 and 7 are discarded.
    - Then: if phase<7, phase+1 and go to SETTLE. If phase=7, pulse frame_strobe this clock, phase=0, go to IDLE.
  - IDLE: JOY_CLK=0, JOY_LOAD=1, joyP7_o=1 for IDLE_CYCLES clocks, then SETTLE.
- Frame length in clocks: SETTLE_CYCLES + CLK_DIV + (2·NBITS−1)·CLK_DIV + 1.
- JOY_DATA is passed through a 2-flop synchronizer. Sample timing above refers to the synchronized signal; sampling at the end of the low half absorbs the 2-clock delay when CLK_DIV≥3.
- All outputs are registered.
- frame_ext is updated every cycle regardless of six_a/six_b; consumers qualify it with the flags.
- Counters are sized by $clog2 of their maximum and wrap only at the terminal counts above.
- JOY_CLK never has a high pulse outside SHIFT_HI. No JOY_CLK edge occurs while JOY_LOAD=0.

Test Plan:
- Reset mid-SHIFT: with CLK_DIV=4, assert reset during bit 7 → next cycle JOY_CLK=0, JOY_LOAD=1, joyP7_o=1, frames=16'hFFFF. After release, the first CAPTURE is phase 0.
- Timing (CLK_DIV=4, SETTLE_CYCLES=8, NBITS=16): JOY_LOAD low for exactly 4 clocks; exactly 15 JOY_CLK high pulses of 4 clocks each per frame; frame length = 137 clocks.
- Data capture: a shift-register model presents 16'hA5C3 when select=1 and 16'h5A3C when select=0 → after the strobe, frame_hi=16'hA5C3 and frame_lo=16'h5A3C.
- 6-button detect: model returns 16'hFFF0 in phase 5 and 16'hFFF6 in phase 6 → six_a=1, six_b=0, frame_ext=16'hFFF6. Next cycle with phase 5 = 16'hFFFF → six_a=0.
- Select/strobe sequencing: joyP7_o follows 1,0,1,0,1,0,1,0 across phases 0–7. frame_strobe pulses exactly once per cycle, then joyP7_o=1 for IDLE_CYCLES clocks before the next load.
- Async JOY_DATA: toggle JOY_DATA asynchronously except in a 3-clock window before each sample point → captured bits match the model. No X propagates to the outputs.
